clkdiv_multi: RTL and testbench

- Parametrised, runtime-programmable multi-channel clock divider; successor to the fixed-ratio divide-by-2..6 block.
- Each channel divides clk by its own integer N, with exactly 50% duty for both odd and even N.
- Divisor changes are glitch-free: a new ratio takes effect only at a period boundary.
- Sits at the top of a design and feeds derived clocks and strobes to downstream blocks.

---
 rtl/clkdiv_multi_if.sv | 26 ++
 rtl/clkdiv_multi.sv | 105 ++++++++++
 tb/tb_clkdiv_multi.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_multi_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master drives enable, restart and divisor loads; the slave returns the clocks, ticks and pending flags.
interface clkdiv_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 4
);

  logic                    en;
  logic                    clr;
  logic                    load;
  logic [NUM_CH*WIDTH-1:0] div_val;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output en, clr, load, div_val,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, clr, load, div_val,
    output clk_out, tick, pending
  );

endinterface

// File: rtl/clkdiv_multi.sv
// NUM_CH independent runtime-programmable clock dividers with 50% duty for odd and even ratios.
// A new ratio is held in a shadow register and only takes over at a period boundary, so it cannot glitch.
module clkdiv_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 2
) (
  input logic           clk,
  input logic           reset,
  clkdiv_multi_if.slave bus
);

  localparam logic [WIDTH-1:0] DivReset = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two      = WIDTH'(2);

  logic [NUM_CH-1:0] w_clkOut;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_pending;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pending;
    logic             r_pos;
    logic             r_neg;
    logic             r_tick;

    logic [WIDTH-1:0] w_req;
    logic [WIDTH-1:0] w_cntInc;
    logic [WIDTH-1:0] w_halfDiv;
    logic [WIDTH-1:0] w_nextDiv;
    logic             w_stopped;
    logic             w_boundary;
    logic             w_apply;
    logic             w_nextRun;

    assign w_req      = bus.div_val[gi*WIDTH +: WIDTH];
    assign w_stopped  = (r_div < Two);
    assign w_boundary = bus.en && !w_stopped && (r_cnt == r_div - One);
    // A stopped channel has no boundary, so a pending divisor is picked up on the next enabled edge.
    assign w_apply    = r_pending && bus.en && !bus.clr && (w_boundary || w_stopped);
    assign w_nextDiv  = w_apply ? r_shadow : r_div;
    assign w_nextRun  = (w_nextDiv >= Two);
    assign w_cntInc   = r_cnt + One;
    assign w_halfDiv  = (r_div >> 1) + WIDTH'(r_div[0]);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt     <= '0;
        r_div     <= DivReset;
        r_shadow  <= DivReset;
        r_pending <= 1'b0;
        r_pos     <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        if (bus.load) begin
          r_shadow  <= w_req;
          r_pending <= 1'b1;
        end else if (w_apply) begin
          r_pending <= 1'b0;
        end

        if (w_apply) begin
          r_div <= r_shadow;
        end

        if (bus.clr) begin
          r_cnt  <= '0;
          r_pos  <= !w_stopped;
          r_tick <= !w_stopped;
        end else if (!bus.en) begin
          r_tick <= 1'b0;
        end else if (w_boundary || w_stopped) begin
          r_cnt  <= '0;
          r_pos  <= w_nextRun;
          r_tick <= w_nextRun;
        end else begin
          r_cnt  <= w_cntInc;
          r_pos  <= (w_cntInc < w_halfDiv);
          r_tick <= 1'b0;
        end
      end
    end

    // Half-cycle delayed copy of pos; ANDing it in trims odd ratios to exactly N/2 periods high.
    always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
        r_neg <= 1'b0;
      end else begin
        r_neg <= r_pos;
      end
    end

    assign w_clkOut[gi]  = r_div[0] ? (r_pos & r_neg) : r_pos;
    assign w_tick[gi]    = r_tick;
    assign w_pending[gi] = r_pending;
  end

  assign bus.clk_out = w_clkOut;
  assign bus.tick    = w_tick;
  assign bus.pending = w_pending;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: a per-cycle vector table for the default and 3/4/5/6 ratios,
// then hand-written sequences for ratio changes, stopped channels, enable freeze, clr and mid-period reset.
module tb_clkdiv_multi;

  localparam int NumCh = 4;
  localparam int Width = 4;

  typedef struct {
    logic        en;
    logic        clr;
    logic        load;
    logic [15:0] divVal;
    logic [3:0]  expOut;
    logic [3:0]  expTick;
    logic [3:0]  expPend;
  } vec_t;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;
  vec_t vecs[19];

  clkdiv_multi_if #(.NUM_CH(NumCh), .WIDTH(Width)) bus ();

  clkdiv_multi #(
    .NUM_CH(NumCh),
    .WIDTH(Width),
    .DEFAULT_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expOut,
                             input logic [3:0] expTick, input logic [3:0] expPend);
    checkVal({name, ".clk_out"}, bus.clk_out, expOut);
    checkVal({name, ".tick"}, bus.tick, expTick);
    checkVal({name, ".pending"}, bus.pending, expPend);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic load, input logic [15:0] divVal);
    bus.en      = en;
    bus.clr     = clr;
    bus.load    = load;
    bus.div_val = divVal;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.load    = 1'b0;
    bus.div_val = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset", 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Length, in half clk periods, of the next complete high pulse on one channel.
  task automatic measureRun(input int ch, output int run);
    int guard;
    guard = 0;
    run   = 0;
    while (bus.clk_out[ch] !== 1'b0 && guard < 40) begin
      @(clk); #1; guard++;
    end
    while (bus.clk_out[ch] !== 1'b1 && guard < 40) begin
      @(clk); #1; guard++;
    end
    while (bus.clk_out[ch] === 1'b1 && guard < 40) begin
      run++;
      @(clk); #1; guard++;
    end
    if (guard >= 40) run = -1;
  endtask

  initial begin
    int highCnt[NumCh];
    int run;
    logic [3:0] n7Out[6];

    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.load    = 1'b0;
    bus.div_val = '0;

    for (int i = 0; i < 6; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b0, 16'h0000, (i % 2 == 1) ? 4'hF : 4'h0, (i % 2 == 1) ? 4'hF : 4'h0, 4'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h6543, 4'b0000, 4'b0000, 4'hF};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1010, 4'b1111, 4'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b0000, 4'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1100, 4'b0000, 4'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0001, 4'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0011, 4'b0010, 4'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0100, 4'h0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1100, 4'b1001, 4'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1101, 4'b0000, 4'h0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1010, 4'b0010, 4'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0001, 4'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0100, 4'h0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0000, 4'h0};

    n7Out[0] = 4'hF; n7Out[1] = 4'hF; n7Out[2] = 4'hF;
    n7Out[3] = 4'h0; n7Out[4] = 4'h0; n7Out[5] = 4'h0;

    doReset();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].divVal);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expTick, vecs[i].expPend);
    end

    // 60 clk is a whole number of periods for 3, 4, 5 and 6, so each channel is high exactly half the samples.
    for (int c = 0; c < NumCh; c++) highCnt[c] = 0;
    for (int h = 0; h < 120; h++) begin
      for (int c = 0; c < NumCh; c++) if (bus.clk_out[c] === 1'b1) highCnt[c]++;
      @(clk); #1;
    end
    for (int c = 0; c < NumCh; c++) checkInt($sformatf("duty_ch%0d", c), highCnt[c], 60);
    measureRun(0, run); checkInt("run_ch0_halves", run, 3);
    measureRun(1, run); checkInt("run_ch1_halves", run, 4);
    measureRun(2, run); checkInt("run_ch2_halves", run, 5);
    measureRun(3, run); checkInt("run_ch3_halves", run, 6);

    // N=8 running, load 3 while cnt==2.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h8888); checkOutput("n8_load", 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n8_start", 4'hF, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n8_cnt1", 4'hF, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n8_cnt2", 4'hF, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h3333); checkOutput("n8_cnt3", 4'hF, 4'h0, 4'hF);
    for (int k = 4; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("n8_cnt%0d", k), 4'h0, 4'h0, 4'hF);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n3_first", 4'h0, 4'hF, 4'h0);
    @(negedge clk); #1;
    checkVal("n3_first_fall.clk_out", bus.clk_out, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n3_cnt1", 4'hF, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n3_cnt2", 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n3_wrap", 4'h0, 4'hF, 4'h0);

    // Two loads before a boundary, then a load exactly at a boundary.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555); checkOutput("dbl_load5", 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h7777); checkOutput("dbl_load7", 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("dbl_cnt1", 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n7_start", 4'h0, 4'hF, 4'h0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("n7_a_cnt%0d", k + 1), n7Out[k], 4'h0, 4'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4444); checkOutput("n7_bnd_load", 4'h0, 4'hF, 4'hF);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("n7_b_cnt%0d", k + 1), n7Out[k], 4'h0, 4'hF);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n4_start", 4'hF, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n4_cnt1", 4'hF, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n4_cnt2", 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n4_cnt3", 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("n4_wrap", 4'hF, 4'hF, 4'h0);

    // Stopped channels (N=0 and N=1), then restart with N=2.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1010); checkOutput("stop_load", 4'h0, 4'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("stopped%0d", k), 4'h0, 4'h0, 4'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h2222); checkOutput("stop_reload", 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("stop_restart", 4'hF, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("stop_run1", 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("stop_run2", 4'hF, 4'hF, 4'h0);

    // Enable freeze, clr realignment with a pending load, then reset mid-period.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h6543); checkOutput("frz_load", 4'h0, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("frz_t0", 4'b1010, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("frz_t1", 4'b1111, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("frz_t2", 4'b1100, 4'h0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("frozen%0d", k), 4'b1100, 4'h0, 4'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("frz_t3", 4'b0000, 4'b0001, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222); checkOutput("clr", 4'b1011, 4'hF, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("clr_t1", 4'b1111, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("clr_t2", 4'b1100, 4'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("clr_ch0_apply", 4'b0001, 4'b0001, 4'b1110);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("clr_ch1_apply", 4'b0010, 4'b0010, 4'b1100);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset", 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("post_rst1", 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("post_rst2", 4'hF, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("post_rst3", 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000); checkOutput("post_rst4", 4'hF, 4'hF, 4'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
